mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 111 +++++++++++
 tb/tb_mem_access_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store unit that decodes, checks and runs one bus access per request
module mem_access_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata_out,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY, FIN} state_t;
  state_t state, next;
  logic l_store;
  logic [2:0] l_f3;
  logic [31:0] l_addr, l_wdata, cnt, r_data, ext;
  logic r_err;
  logic [1:0] r_code;
  logic ill, mis, tout, busy, fin;
  logic [7:0] b;
  logic [15:0] h;
  // decode checks on the incoming request, timeout detect and load extraction
  always_comb begin
    ill = is_store ? (func3 > 3'd2) : (func3 == 3'b011 || func3[2:1] == 2'b11);
    mis = func3[1:0] == 2'b01 ? addr[0] : func3[1:0] == 2'b10 ? |addr[1:0] : 1'b0;
    tout = cnt == 32'(TIMEOUT - 1);
    b = bus_rdata[{l_addr[1:0], 3'b000} +: 8];
    h = l_addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    ext = l_f3 == 3'b000 ? {{24{b[7]}}, b} :
          l_f3 == 3'b001 ? {{16{h[15]}}, h} :
          l_f3 == 3'b100 ? {24'b0, b} :
          l_f3 == 3'b101 ? {16'b0, h} : bus_rdata;
  end
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : next;
  // next-state logic; start outside IDLE is ignored
  always_comb begin
    next = state;
    case (state)
      IDLE: next = start ? ((ill | mis) ? FIN : BUSY) : IDLE;
      BUSY: next = (bus_ack | tout) ? FIN : BUSY;
      default: next = IDLE;
    endcase
  end
  // request latch, wait counter and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      l_store <= 1'b0;
      l_f3 <= '0;
      l_addr <= '0;
      l_wdata <= '0;
      cnt <= '0;
      r_err <= 1'b0;
      r_code <= '0;
      r_data <= '0;
    end else if (state == IDLE && start) begin
      l_store <= is_store;
      l_f3 <= func3;
      l_addr <= addr;
      l_wdata <= wdata;
      cnt <= '0;
      r_err <= ill | mis;
      r_code <= ill ? 2'b10 : mis ? 2'b01 : 2'b00;
      r_data <= '0;
    end else if (state == BUSY) begin
      if (bus_ack) begin
        r_err <= 1'b0;
        r_code <= 2'b00;
        r_data <= l_store ? '0 : ext;
      end else if (tout) begin
        r_err <= 1'b1;
        r_code <= 2'b11;
        r_data <= '0;
      end else
        cnt <= cnt + 32'd1;
    end
  end
  // outputs: bus fields from latched request while busy, results only in FIN
  always_comb begin
    busy = state == BUSY;
    fin = state == FIN;
    stall = (state == IDLE && start) || busy;
    done = fin;
    rdata_out = fin ? r_data : '0;
    err = fin & r_err;
    err_code = fin ? r_code : 2'b00;
    bus_req = busy;
    bus_we = busy & l_store;
    bus_addr = busy ? {l_addr[31:2], 2'b00} : '0;
    bus_be = !busy ? 4'b0000 : !l_store ? 4'b1111 :
             l_f3 == 3'b000 ? 4'b0001 << l_addr[1:0] :
             l_f3 == 3'b001 ? 4'b0011 << {l_addr[1], 1'b0} : 4'b1111;
    bus_wdata = !(busy & l_store) ? '0 :
                l_f3 == 3'b000 ? {4{l_wdata[7:0]}} :
                l_f3 == 3'b001 ? {2{l_wdata[15:0]}} : l_wdata;
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;
  localparam int TO = 4;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, is_store = 1'b0, bus_ack = 1'b0;
  logic [2:0] func3 = '0;
  logic [31:0] addr = '0, wdata = '0, bus_rdata = '0;
  logic stall, done, err, bus_req, bus_we;
  logic [1:0] err_code;
  logic [31:0] rdata_out, bus_addr, bus_wdata;
  logic [3:0] bus_be;
  int vec = 0, bad = 0, cyc = 0;
  typedef struct {logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wd; int nreq;} bus_t;
  typedef struct {int cyc; logic err; logic [1:0] code; logic [31:0] rd;} done_t;
  bus_t bq[$];
  done_t dq[$];
  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store), .func3(func3),
    .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata_out(rdata_out),
    .err(err), .err_code(err_code), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  bus_t cur;
  bus_t eb;
  done_t ed;
  logic req_q = 1'b0;
  int nreq = 0;
  // monitor: bus requests and completions popped from the scoreboard queues
  always @(negedge clk) begin
    if (bus_req) begin
      if (!req_q) begin
        if (bq.size() == 0) chk("unexpected_bus_req", 1, 0);
        else begin
          eb = bq.pop_front();
          chk("bus_we", bus_we, eb.we);
          chk("bus_addr", bus_addr, eb.addr);
          chk("bus_be", bus_be, eb.be);
          chk("bus_wdata", bus_wdata, eb.wd);
        end
        cur = '{bus_we, bus_addr, bus_be, bus_wdata, 0};
        nreq = 0;
      end else begin
        chk("hold_addr", bus_addr, cur.addr);
        chk("hold_be_we", {bus_be, bus_we}, {cur.be, cur.we});
        chk("hold_wdata", bus_wdata, cur.wd);
      end
      nreq++;
      chk("stall_busy", stall, 1);
    end else if (req_q)
      chk("bus_req_cycles", nreq, eb.nreq);
    req_q = bus_req;
    if (done) begin
      if (dq.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        ed = dq.pop_front();
        chk("done_cycle", cyc, ed.cyc);
        chk("err", err, ed.err);
        chk("err_code", err_code, ed.code);
        chk("rdata_out", rdata_out, ed.rd);
      end
      chk("stall_fin", stall, 0);
    end
  end
  task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input int n, input logic [31:0] rd, input logic hold, input logic [3:0] e_be,
                     input logic [31:0] e_wd, input logic e_err, input logic [1:0] e_code, input logic [31:0] e_rd);
    int t0, nr;
    bit dec_err;
    @(posedge clk); #1;
    start = 1'b1; is_store = st; func3 = f3; addr = a; wdata = wd;
    t0 = cyc;
    dec_err = e_err && e_code != 2'b11;
    nr = n == 0 ? TO : n;
    if (!dec_err) bq.push_back('{st, {a[31:2], 2'b00}, e_be, e_wd, nr});
    dq.push_back('{dec_err ? t0 + 1 : t0 + nr + 1, e_err, e_code, e_rd});
    @(negedge clk);
    chk("stall_start", stall, 1);
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    for (int i = 1; i <= n; i++) begin
      if (i == n) begin bus_ack = 1'b1; bus_rdata = rd; end
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
    if (hold) begin @(posedge clk); #1; end
    start = 1'b0;
    repeat (TO + 3) @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_done_err", {done, err, err_code}, 0);
    chk("rst_bus", {bus_req, bus_we, bus_be}, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_rdata", rdata_out, 0);
    @(posedge clk); #1 reset = 1'b0;
    //  st  f3      addr          wdata         n  bus_rdata     hold be       e_wd          err  code   rdata
    txn(0, 3'b010, 32'h100, 32'h0, 2, 32'hDEADBEEF, 0, 4'b1111, 32'h0, 0, 2'b00, 32'hDEADBEEF);
    txn(0, 3'b000, 32'h103, 32'h0, 1, 32'h80FFFF00, 0, 4'b1111, 32'h0, 0, 2'b00, 32'hFFFFFF80);
    txn(0, 3'b100, 32'h103, 32'h0, 1, 32'h80FFFF00, 0, 4'b1111, 32'h0, 0, 2'b00, 32'h00000080);
    txn(1, 3'b001, 32'h202, 32'h1234ABCD, 1, 32'h55555555, 0, 4'b1100, 32'hABCDABCD, 0, 2'b00, 32'h0);
    txn(0, 3'b010, 32'h101, 32'h0, 0, 32'h0, 0, 4'b0, 32'h0, 1, 2'b01, 32'h0);
    txn(0, 3'b011, 32'h100, 32'h0, 0, 32'h0, 0, 4'b0, 32'h0, 1, 2'b10, 32'h0);
    txn(0, 3'b010, 32'h100, 32'h0, 0, 32'h0, 0, 4'b1111, 32'h0, 1, 2'b11, 32'h0);
    txn(0, 3'b010, 32'h104, 32'h0, 4, 32'h0BADF00D, 0, 4'b1111, 32'h0, 0, 2'b00, 32'h0BADF00D);
    txn(1, 3'b000, 32'h301, 32'h000000A5, 1, 32'h0, 0, 4'b0010, 32'hA5A5A5A5, 0, 2'b00, 32'h0);
    txn(1, 3'b010, 32'h400, 32'hCAFEF00D, 3, 32'h0, 0, 4'b1111, 32'hCAFEF00D, 0, 2'b00, 32'h0);
    txn(0, 3'b001, 32'h102, 32'h0, 1, 32'h80011234, 0, 4'b1111, 32'h0, 0, 2'b00, 32'hFFFF8001);
    txn(0, 3'b101, 32'h100, 32'h0, 1, 32'h8001F234, 0, 4'b1111, 32'h0, 0, 2'b00, 32'h0000F234);
    txn(1, 3'b001, 32'h201, 32'h0, 0, 32'h0, 0, 4'b0, 32'h0, 1, 2'b01, 32'h0);
    txn(1, 3'b011, 32'h200, 32'h0, 0, 32'h0, 0, 4'b0, 32'h0, 1, 2'b10, 32'h0);
    txn(1, 3'b100, 32'h200, 32'h0, 0, 32'h0, 0, 4'b0, 32'h0, 1, 2'b10, 32'h0);
    txn(0, 3'b111, 32'h101, 32'h0, 0, 32'h0, 0, 4'b0, 32'h0, 1, 2'b10, 32'h0);
    txn(0, 3'b010, 32'h108, 32'h0, 1, 32'h13579BDF, 1, 4'b1111, 32'h0, 0, 2'b00, 32'h13579BDF);
    @(posedge clk); #1;
    start = 1'b1; is_store = 1'b0; func3 = 3'b010; addr = 32'h100;
    bq.push_back('{1'b0, 32'h100, 4'b1111, 32'h0, 2});
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("abort_bus_req", bus_req, 0);
    chk("abort_done", done, 0);
    chk("abort_stall", stall, 0);
    @(posedge clk); #1 bus_ack = 1'b0;
    repeat (4) @(posedge clk);
    txn(0, 3'b010, 32'h10C, 32'h0, 2, 32'h2468ACE0, 0, 4'b1111, 32'h0, 0, 2'b00, 32'h2468ACE0);
    chk("bus_queue_empty", bq.size(), 0);
    chk("done_queue_empty", dq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
